// File: rtl/vp_sched_pkg.sv
// Shared encodings and sizing constants for the video line scheduler.
package vp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  localparam int OUTSTANDING_W   = 8;
  localparam int DEFAULT_COLUMNS = 80;

endpackage

// File: rtl/vp_credit_counter.sv
// Tracks characters in flight between the memory ack and the pixel-FIFO write,
// and decides whether another character may be issued.
module vp_credit_counter
  import vp_sched_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_inc,
  input  logic                     i_dec_req,
  input  logic [OUTSTANDING_W-1:0] i_pix_free,
  output logic [OUTSTANDING_W-1:0] o_outstanding,
  output logic                     o_dec_pending,
  output logic                     o_can_issue
);

  localparam logic [OUTSTANDING_W-1:0] MAX_C = OUTSTANDING_W'(MAX_OUTSTANDING);

  logic [OUTSTANDING_W-1:0] r_count;
  logic                     r_dec_pend;

  // The decrement lags the pipeline output by one cycle so that it lands together
  // with the pix_free drop caused by the matching FIFO write.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_dec_pend <= 1'b0;
    end else begin
      r_dec_pend <= i_dec_req;
      if (i_inc && !r_dec_pend) begin
        r_count <= r_count + OUTSTANDING_W'(1);
      end else if (!i_inc && r_dec_pend && (r_count != '0)) begin
        r_count <= r_count - OUTSTANDING_W'(1);
      end
    end
  end

  assign o_outstanding = r_count;
  assign o_dec_pending = r_dec_pend;
  assign o_can_issue   = (r_count < i_pix_free) && (r_count < MAX_C);

endmodule

// File: rtl/vp_line_scheduler.sv
// Fetches one text row of character/attribute words and feeds them to vp_pipeline,
// issuing each character only against a reserved pixel-FIFO slot.
module vp_line_scheduler
  import vp_sched_pkg::*;
#(
  parameter int COLUMNS         = DEFAULT_COLUMNS,
  parameter int ADDR_WIDTH      = 12,
  parameter int MAX_OUTSTANDING = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_start,
  input  logic [ADDR_WIDTH-1:0] line_base,
  input  logic [4:0]            char_row_in,
  input  logic [3:0]            ypos_in,
  input  logic [6:0]            frame_count_in,
  output logic                  line_busy,
  output logic                  line_done,
  output logic                  line_overrun,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_data,
  output logic [31:0]           vp_charattr,
  output logic [4:0]            vp_char_row,
  output logic [3:0]            vp_ypos,
  output logic [6:0]            vp_frame_count,
  output logic                  vp_enabled,
  input  logic [63:0]           vp_pixels,
  input  logic                  vp_enable,
  output logic [63:0]           pix_data,
  output logic                  pix_valid,
  input  logic [7:0]            pix_free
);

  localparam int               COL_W    = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);

  sched_state_e             r_state, w_next_state;
  logic [COL_W-1:0]         r_col;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic                     r_req_hold;
  logic [31:0]              r_charattr;
  logic [4:0]               r_char_row;
  logic [3:0]               r_ypos;
  logic [6:0]               r_frame_count;
  logic                     r_vp_enabled, r_pix_valid, r_line_done, r_line_overrun;
  logic [63:0]              r_pix_data;
  logic                     w_fire, w_accept, w_overrun, w_done;
  logic                     w_can_issue, w_dec_pending;
  logic [OUTSTANDING_W-1:0] w_outstanding;

  vp_credit_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_credit (
    .clk           (clk),
    .reset         (reset),
    .i_inc         (w_fire),
    .i_dec_req     (vp_enable),
    .i_pix_free    (pix_free),
    .o_outstanding (w_outstanding),
    .o_dec_pending (w_dec_pending),
    .o_can_issue   (w_can_issue)
  );

  // Once raised, the request is held by r_req_hold even if credit drops before the ack.
  assign mem_req = (r_state == ST_FETCH) && (w_can_issue || r_req_hold);
  assign w_fire  = mem_req && mem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every output of this block is given a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The cycle showing line_done still counts as busy for a new line_start.
        if (line_start && !r_line_done) begin
          w_accept     = 1'b1;
          w_next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (w_fire && (r_col == LAST_COL)) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((w_outstanding == '0) && !w_dec_pending) begin
          w_done       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    w_overrun = line_start && !w_accept;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col          <= '0;
      r_addr         <= '0;
      r_req_hold     <= 1'b0;
      r_charattr     <= '0;
      r_char_row     <= '0;
      r_ypos         <= '0;
      r_frame_count  <= '0;
      r_vp_enabled   <= 1'b0;
      r_pix_valid    <= 1'b0;
      r_pix_data     <= '0;
      r_line_done    <= 1'b0;
      r_line_overrun <= 1'b0;
    end else begin
      r_req_hold     <= mem_req && !mem_ack;
      r_vp_enabled   <= w_fire;
      r_pix_valid    <= vp_enable;
      r_pix_data     <= vp_pixels;
      r_line_done    <= w_done;
      r_line_overrun <= w_overrun;
      if (w_fire) r_charattr <= mem_data;
      if (w_accept) begin
        r_col         <= '0;
        r_addr        <= line_base;
        r_char_row    <= char_row_in;
        r_ypos        <= ypos_in;
        r_frame_count <= frame_count_in;
      end else if (w_fire) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        if (r_col != LAST_COL) r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign line_busy      = (r_state != ST_IDLE);
  assign line_done      = r_line_done;
  assign line_overrun   = r_line_overrun;
  assign mem_addr       = r_addr;
  assign vp_charattr    = r_charattr;
  assign vp_char_row    = r_char_row;
  assign vp_ypos        = r_ypos;
  assign vp_frame_count = r_frame_count;
  assign vp_enabled     = r_vp_enabled;
  assign pix_data       = r_pix_data;
  assign pix_valid      = r_pix_valid;

endmodule

// File: tb/tb_vp_line_scheduler.sv
// Scoreboard bench for vp_line_scheduler: bench-side memory, 3-cycle pipeline and
// pixel-FIFO models; a negedge monitor compares DUT outputs against queued expectations.
module tb_vp_line_scheduler;
  import vp_sched_pkg::*;

  localparam int COLS = 4;
  localparam int AW   = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          line_start = 1'b0;
  logic [AW-1:0] line_base = '0;
  logic [4:0]    char_row_in = '0;
  logic [3:0]    ypos_in = '0;
  logic [6:0]    frame_count_in = '0;
  logic          line_busy, line_done, line_overrun, mem_req, mem_ack, vp_enabled;
  logic          vp_enable, pix_valid;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data, vp_charattr;
  logic [4:0]    vp_char_row;
  logic [3:0]    vp_ypos;
  logic [6:0]    vp_frame_count;
  logic [63:0]   vp_pixels, pix_data;
  logic [7:0]    pix_free;

  always #5 clk = ~clk;

  vp_line_scheduler #(.COLUMNS(COLS), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(15)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_base(line_base),
    .char_row_in(char_row_in), .ypos_in(ypos_in), .frame_count_in(frame_count_in),
    .line_busy(line_busy), .line_done(line_done), .line_overrun(line_overrun),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .vp_charattr(vp_charattr), .vp_char_row(vp_char_row), .vp_ypos(vp_ypos),
    .vp_frame_count(vp_frame_count), .vp_enabled(vp_enabled), .vp_pixels(vp_pixels),
    .vp_enable(vp_enable), .pix_data(pix_data), .pix_valid(pix_valid), .pix_free(pix_free)
  );

  // Memory: acks after wait_cfg stall cycles; data is a known function of the address.
  logic [3:0] wait_cfg = 4'd0;
  logic [3:0] wait_cnt = 4'd0;
  assign mem_ack  = mem_req && (wait_cnt == wait_cfg);
  assign mem_data = {20'hCAFE0, mem_addr};
  always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 4'd1 : 4'd0;

  // Pipeline: returns pixels 3 cycles after vp_enabled; never reset.
  logic [2:0]  pv = 3'b000;
  logic [31:0] pd0 = '0, pd1 = '0, pd2 = '0;
  always @(posedge clk) begin
    pv  <= {pv[1:0], vp_enabled};
    pd0 <= vp_charattr;
    pd1 <= pd0;
    pd2 <= pd1;
  end
  assign vp_enable = pv[2];
  assign vp_pixels = {pd2, ~pd2};

  // Pixel FIFO that never drains: free space drops one cycle after each write.
  logic [7:0] used = 8'd0;
  logic [7:0] free_cap = 8'd16;
  always @(posedge clk) if (pix_valid) used <= used + 8'd1;
  assign pix_free = free_cap - used;

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0, done_cnt = 0, ovr_cnt = 0, stray_cnt = 0;
  int exp_done = 0, exp_ovr = 0;
  bit sb_pix_on = 1'b1;
  logic [AW-1:0] exp_addr[$];
  logic [63:0]   exp_pix[$];
  logic [4:0]    exp_row = '0;
  logic [3:0]    exp_ypos = '0;
  logic [6:0]    exp_fc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pix_of(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {20'hCAFE0, a};
    return {w, ~w};
  endfunction

  // Monitor
  logic          p_rst = 1'b0, p_req = 1'b0, p_ack = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [31:0]   p_data = '0;
  always @(negedge clk) begin
    if (reset) begin
      if (mem_req && mem_ack) begin
        ack_cnt++;
        if (exp_addr.size() == 0) check("unexpected_req", 64'(mem_addr), 64'hFFFF);
        else check("mem_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
      end
      if (pix_valid) begin
        if (!sb_pix_on) stray_cnt++;
        else if (exp_pix.size() == 0) check("unexpected_pix", pix_data, 64'hDEAD);
        else check("pix_data", pix_data, exp_pix.pop_front());
      end
      if (p_rst && p_req && !p_ack) begin
        check("req_hold", 64'(mem_req), 64'd1);
        check("addr_hold", 64'(mem_addr), 64'(p_addr));
      end
      if (p_rst) begin
        check("vp_enabled", 64'(vp_enabled), 64'(p_req && p_ack));
        if (p_req && p_ack) check("vp_charattr", 64'(vp_charattr), 64'(p_data));
      end
      if (vp_enabled) begin
        check("vp_char_row", 64'(vp_char_row), 64'(exp_row));
        check("vp_ypos", 64'(vp_ypos), 64'(exp_ypos));
        check("vp_frame_count", 64'(vp_frame_count), 64'(exp_fc));
      end
      if (line_done) begin
        done_cnt++;
        check("busy_low_with_done", 64'(line_busy), 64'd0);
      end
      if (line_overrun) ovr_cnt++;
    end
    p_rst  = reset;
    p_req  = mem_req;
    p_ack  = mem_ack;
    p_addr = mem_addr;
    p_data = mem_data;
  end

  task automatic start_line(input logic [AW-1:0] base, input logic [4:0] row,
                            input logic [3:0] y, input logic [6:0] fc);
    @(posedge clk); #1;
    line_start = 1'b1; line_base = base;
    char_row_in = row; ypos_in = y; frame_count_in = fc;
    for (int i = 0; i < COLS; i++) begin
      exp_addr.push_back(base + AW'(i));
      exp_pix.push_back(pix_of(base + AW'(i)));
    end
    exp_row = row; exp_ypos = y; exp_fc = fc;
    exp_done++;
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic overrun_pulse(input logic [4:0] row);
    @(posedge clk); #1;
    line_start = 1'b1; line_base = 12'h777; char_row_in = row;
    @(posedge clk); #1;
    line_start = 1'b0;
    exp_ovr++;
  endtask

  task automatic wait_acks(input int target);
    bit reached = 1'b0;
    for (int k = 0; k < 400 && !reached; k++) begin
      if (ack_cnt >= target) reached = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("ack_wait", 64'(reached), 64'd1);
  endtask

  task automatic wait_done(input bit start_on_done);
    bit seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(posedge clk); #1;
      seen = line_done;
    end
    check("line_done_seen", 64'(seen), 64'd1);
    if (start_on_done && seen) begin
      line_start = 1'b1; char_row_in = 5'h1F; line_base = 12'h123;
      @(posedge clk); #1;
      line_start = 1'b0;
      exp_ovr++;
      check("done_start_overrun", 64'(line_overrun), 64'd1);
      check("done_start_busy", 64'(line_busy), 64'd0);
    end
  endtask

  int a0;

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_vp_enabled", 64'(vp_enabled), 64'd0);
    check("rst_pix_valid", 64'(pix_valid), 64'd0);
    check("rst_pix_data", pix_data, 64'd0);
    check("rst_busy", 64'(line_busy), 64'd0);
    check("rst_done", 64'(line_done), 64'd0);
    check("rst_overrun", 64'(line_overrun), 64'd0);
    check("rst_charattr", 64'(vp_charattr), 64'd0);
    check("rst_ctx", 64'({vp_char_row, vp_ypos, vp_frame_count}), 64'd0);
    check("rst_state", 64'(dut.r_state), 64'(ST_IDLE));
    @(posedge clk); #1;
    reset = 1'b1;

    // Basic row, then a line_start coinciding with line_done
    wait_cfg = 4'd0;
    free_cap = used + 8'd16;
    start_line(12'h100, 5'd3, 4'd5, 7'd42);
    wait_done(1'b1);
    check("basic_addr_q_empty", 64'(exp_addr.size()), 64'd0);
    check("basic_pix_q_empty", 64'(exp_pix.size()), 64'd0);
    check("ctx_after_overrun", 64'(vp_char_row), 64'd3);

    // Credit limit
    repeat (4) @(posedge clk); #1;
    free_cap = used + 8'd2;
    a0 = ack_cnt;
    start_line(12'h180, 5'd4, 4'd1, 7'd2);
    repeat (30) @(posedge clk); #1;
    check("credit_issued", 64'(ack_cnt - a0), 64'd2);
    check("credit_req_low", 64'(mem_req), 64'd0);
    check("credit_busy", 64'(line_busy), 64'd1);
    free_cap = free_cap + 8'd2;
    wait_done(1'b0);
    check("credit_total", 64'(ack_cnt - a0), 64'd4);

    // Wait states
    wait_cfg = 4'd3;
    free_cap = used + 8'd16;
    start_line(12'h200, 5'd6, 4'd7, 7'd8);
    wait_done(1'b0);

    // Overrun mid-FETCH
    a0 = ack_cnt;
    start_line(12'h300, 5'd5, 4'd9, 7'd11);
    wait_acks(a0 + 1);
    overrun_pulse(5'd9);
    @(posedge clk); #1;
    check("overrun_pulses", 64'(ovr_cnt), 64'(exp_ovr));
    check("overrun_ctx_kept", 64'(vp_char_row), 64'd5);
    check("overrun_busy", 64'(line_busy), 64'd1);
    wait_done(1'b0);
    check("overrun_chars", 64'(ack_cnt - a0), 64'd4);

    // Address wrap
    wait_cfg = 4'd0;
    free_cap = used + 8'd16;
    start_line(12'hFFE, 5'd1, 4'd2, 7'd3);
    wait_done(1'b0);

    // Reset mid-line
    wait_cfg = 4'd2;
    a0 = ack_cnt;
    start_line(12'h400, 5'd7, 4'd2, 7'd9);
    wait_acks(a0 + 2);
    reset = 1'b0;
    exp_addr.delete();
    exp_pix.delete();
    exp_done--;
    sb_pix_on = 1'b0;
    exp_row = '0; exp_ypos = '0; exp_fc = '0;
    @(negedge clk);
    check("mid_rst_mem_req", 64'(mem_req), 64'd0);
    check("mid_rst_outputs", 64'({line_busy, line_done, line_overrun, vp_enabled, pix_valid}), 64'd0);
    check("mid_rst_data", 64'({mem_addr, vp_charattr}) | pix_data, 64'd0);
    check("mid_rst_state", 64'(dut.r_state), 64'(ST_IDLE));
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    repeat (8) @(posedge clk); #1;
    sb_pix_on = 1'b1;
    free_cap = used + 8'd16;
    start_line(12'h500, 5'd2, 4'd3, 7'd4);
    wait_done(1'b0);

    repeat (4) @(posedge clk); #1;
    check("final_addr_q_empty", 64'(exp_addr.size()), 64'd0);
    check("final_pix_q_empty", 64'(exp_pix.size()), 64'd0);
    check("done_count", 64'(done_cnt), 64'(exp_done));
    check("overrun_count", 64'(ovr_cnt), 64'(exp_ovr));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vp_line_scheduler.md
# vp_line_scheduler

Sequences one text row of a scanline through `vp_pipeline`. On each line start it fetches `COLUMNS` character/attribute words from video memory, one request at a time, and presents each to the pipeline with the row context latched at line start. The pipeline cannot stall, so the block issues a character only when a downstream pixel-FIFO slot is reserved for it, then forwards the returned 64-bit pixel words. It sits between the video-memory arbiter and the pixel FIFO, wrapping `vp_pipeline`.

## Interface
- `COLUMNS`, 80: characters per row; must be ≥ 1.
- `ADDR_WIDTH`, 12: video-memory word-address width.
- `MAX_OUTSTANDING`, 15: cap on in-flight characters; must be ≤ 255.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low.
- `line_start` in 1: one-cycle pulse; begin a row.
- `line_base` in ADDR_WIDTH: address of column 0; sampled with `line_start`.
- `char_row_in` in 5, `ypos_in` in 4, `frame_count_in` in 7: row context; sampled with `line_start`.
- `line_busy` out 1: high from acceptance to completion.
- `line_done` out 1: one-cycle pulse when the last pixel word has been forwarded.
- `line_overrun` out 1: one-cycle pulse when `line_start` arrives while busy.
- `mem_req` out 1, `mem_addr` out ADDR_WIDTH: read request; held stable until ack.
- `mem_ack` in 1, `mem_data` in 32: data is valid in the ack cycle.
- `vp_charattr` out 32, `vp_char_row` out 5, `vp_ypos` out 4, `vp_frame_count` out 7, `vp_enabled` out 1: pipeline inputs.
- `vp_pixels` in 64, `vp_enable` in 1: pipeline outputs.
- `pix_data` out 64, `pix_valid` out 1: pixel-FIFO write port.
- `pix_free` in 8: FIFO free words. It decreases only through this block's writes and reflects a write one cycle later.

## Operation
- FSM states are IDLE, FETCH and DRAIN.
- **IDLE**
  - On `line_start`: latch the context, set `col`=0 and `addr`=`line_base`, then go to FETCH.
- **FETCH**
  - Assert `mem_req` only when `outstanding < pix_free` and `outstanding < MAX_OUTSTANDING`.
  - Once asserted, `mem_req` and `mem_addr` hold until `mem_ack`.
  - On `mem_req && mem_ack`:
    - `outstanding` += 1.
    - Capture `mem_data` into `vp_charattr`.
    - `addr` += 1, wrapping modulo 2^ADDR_WIDTH.
    - If `col == COLUMNS-1`, go to DRAIN; else `col` += 1.
  - `mem_ack` without `mem_req` is ignored.
- **DRAIN**
  - When `outstanding == 0` and no decrement is pending: pulse `line_done` and return to IDLE.
- **Pixel forwarding** (in every state)
  - `vp_enable` is registered to `pix_valid`, and `vp_pixels` to `pix_data`.
  - `outstanding` decrements in the cycle after `pix_valid`, once `pix_free` has absorbed the write.
  - The decrement saturates at 0: a spurious `vp_enable` is still forwarded but does not underflow the count.
- **Simultaneous events**
  - Increment and decrement in the same cycle leave `outstanding` unchanged.
- **Overrun**
  - `line_start` in FETCH or DRAIN is ignored: the context is unchanged and `line_overrun` pulses.
  - `line_start` in the same cycle as `line_done` is also an overrun.
- **Row context**
  - `vp_char_row`, `vp_ypos` and `vp_frame_count` show the latched context.
  - They update only on an accepted `line_start`.

## Timing
- `mem_ack` at cycle t gives `vp_enabled`=1 with the data at t+1; `vp_enabled` is a one-cycle pulse per character.
- `vp_enable` at t gives `pix_valid` at t+1.
- The `outstanding` decrement takes effect at t+2.
- `line_done` occurs one cycle after the last decrement takes effect.
- With zero-wait memory (ack in the request cycle) and ample credit, throughput is one character per cycle.
- Reset values:
  - FSM is IDLE.
  - `col`, `addr` and `outstanding` are 0.
  - All outputs are 0 (`mem_req`, `vp_enabled`, `pix_valid`, `line_busy`, `line_done`, `line_overrun`, and all data outputs).
- Reset mid-line aborts immediately. In-flight pipeline words arriving after reset are forwarded but are not counted.

## Structure
- Package `vp_sched_pkg` holds:
  - the state encoding (IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2);
  - the `outstanding` width (8);
  - the default `COLUMNS` constant.
- Sub-module `vp_credit_counter` contains the saturating up/down counter, the delayed decrement and the `can_issue` compare against `pix_free`/`MAX_OUTSTANDING`.
- The top level contains the FSM, address/column counters, context registers and output registers.

## Test plan
- **Basic row:** COLUMNS=4, `line_base`=0x100, memory acks at once, `pix_free`=16, pipeline returns 3 cycles after `vp_enabled` → `mem_addr` 0x100–0x103; 4 `pix_valid` words in order; `line_done` once, `line_busy` drops with it.
- **Credit limit:** `pix_free`=2, downstream never drains → exactly 2 characters issued, `mem_req` stays low. Raise `pix_free` to 4 → the remaining 2 issue; line completes.
- **Wait states:** ack delayed 3 cycles per request → `mem_addr` stable while `mem_req` is high; `vp_enabled` one cycle after each ack; no duplicate addresses.
- **Overrun:** `line_start` mid-FETCH with different `char_row_in` → `line_overrun` pulse; `vp_char_row` unchanged; line still ends after COLUMNS characters.
- **Address wrap:** `line_base`=0xFFE, COLUMNS=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- **Reset mid-line:** `reset` low after 2 of 4 acks → all outputs 0 and state IDLE. A new `line_start` after release completes a clean row.
